// File: rtl/muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : muldiv_pkg                                                   |
// | Shared definitions for the multiply/divide engine: op encodings, the   |
// | FSM state type and the default datapath/counter widths.                |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : muldiv_divider                                               |
// | Restoring unsigned divide datapath, one quotient bit per step.         |
// | Ports   : clk, clr (async reset), load (capture operands), step        |
// |           (advance one iteration), dividend/divisor (magnitudes),      |
// |           quo_next/rem_next (result of the step taken this cycle).     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] quo;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  // One extra bit holds the partial remainder shifted left before the compare.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, dsr});
  assign diff     = shifted - {1'b0, dsr};
  assign rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mul_div_unit                                                 |
// | Multi-cycle multiply/divide engine feeding the HI/LO register pair.    |
// | Ports   : clk, clr (async reset), start/op/A/B (request from EX),      |
// |           busy (MUL/DIV in flight), done + WE_HI/WE_LO (one-cycle      |
// |           write pulse), HI_wdata/LO_wdata (write data).                |
// | Config  : MULDIV_FAST_MUL_EN - single-cycle combinational MULT/MULTU.  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             WE_HI,
  output logic             WE_LO,
  output logic [WIDTH-1:0] HI_wdata,
  output logic [WIDTH-1:0] LO_wdata
);

  localparam int C_CNT_W = ($clog2(WIDTH) + 1 > CNT_W) ? $clog2(WIDTH) + 1 : CNT_W;

  state_t             state;
  logic [C_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]   mcand;      // multiplicand magnitude
  logic [2*WIDTH-1:0] prod;       // {partial sum, unconsumed multiplier bits}
  logic               neg_q;      // negate product / quotient at the end
  logic               neg_r;      // negate remainder (dividend was negative)
  logic               div_zero;
  logic [WIDTH-1:0]   a_hold;     // raw dividend, returned in HI on divide by zero

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               last_iter;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = is_signed & A[WIDTH-1];
  assign b_neg     = is_signed & B[WIDTH-1];
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;
  assign last_iter = (cnt == C_CNT_W'(WIDTH - 1));

  // Shift-add multiply step; the final step is folded straight into the write data.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] prod_fix;
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
  assign prod_next = {mul_sum, prod[WIDTH-1:1]};
  assign prod_fix  = neg_q ? -prod_next : prod_next;

  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             div_load;

  assign div_load = start && !busy && ((op == OP_DIV) || (op == OP_DIVU));
  assign quo_fix  = neg_q ? -quo_next : quo_next;
  assign rem_fix  = neg_r ? -rem_next : rem_next;

  muldiv_divider #(.WIDTH(WIDTH)) u_divider (
    .clk      (clk),
    .clr      (clr),
    .load     (div_load),
    .step     (state == DIV),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag;
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      WE_HI    <= 1'b0;
      WE_LO    <= 1'b0;
      HI_wdata <= '0;
      LO_wdata <= '0;
      mcand    <= '0;
      prod     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_hold   <= '0;
    end else begin
      done  <= 1'b0;
      WE_HI <= 1'b0;
      WE_LO <= 1'b0;
      case (state)
        // busy is low in both IDLE and DONE, so requests are accepted in either.
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                HI_wdata <= fast_prod[2*WIDTH-1:WIDTH];
                LO_wdata <= fast_prod[WIDTH-1:0];
                WE_HI    <= 1'b1;
                WE_LO    <= 1'b1;
                done     <= 1'b1;
`else
                state <= MUL;
                busy  <= 1'b1;
                cnt   <= '0;
                mcand <= a_mag;
                prod  <= {{WIDTH{1'b0}}, b_mag};
                neg_q <= a_neg ^ b_neg;
`endif
              end
              OP_DIV, OP_DIVU: begin
                state    <= DIV;
                busy     <= 1'b1;
                cnt      <= '0;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (B == '0);
                a_hold   <= A;
              end
              OP_MTHI: begin
                HI_wdata <= A;
                WE_HI    <= 1'b1;
                done     <= 1'b1;
              end
              OP_MTLO: begin
                LO_wdata <= A;
                WE_LO    <= 1'b1;
                done     <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + C_CNT_W'(1);
          if (last_iter) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            WE_HI    <= 1'b1;
            WE_LO    <= 1'b1;
            HI_wdata <= prod_fix[2*WIDTH-1:WIDTH];
            LO_wdata <= prod_fix[WIDTH-1:0];
          end
        end
        DIV: begin
          cnt <= cnt + C_CNT_W'(1);
          if (last_iter) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            WE_HI    <= 1'b1;
            WE_LO    <= 1'b1;
            HI_wdata <= div_zero ? a_hold : rem_fix;
            LO_wdata <= div_zero ? '1 : quo_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_mul_div_unit                                              |
// | Directed self-checking bench for mul_div_unit (WIDTH = 32).            |
// | Honours MULDIV_FAST_MUL_EN for the expected multiply timing.           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         WE_HI;
  logic         WE_LO;
  logic [W-1:0] HI_wdata;
  logic [W-1:0] LO_wdata;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .WE_HI    (WE_HI),
    .WE_LO    (WE_LO),
    .HI_wdata (HI_wdata),
    .LO_wdata (LO_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request before edge N; return 1 time unit after edge N.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 32'h55AA_55AA;  // operands must already be latched
    B = 32'h0F0F_0F0F;
  endtask

  // Full op with timing checks; returns in the write-pulse cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int inject);
    bit iterative;
    iterative = (o == 3'b010) || (o == 3'b011);
`ifndef MULDIV_FAST_MUL_EN
    iterative = iterative || (o == 3'b000) || (o == 3'b001);
`endif
    issue(o, a, b);
    if (iterative) begin
      for (int k = 1; k <= W; k++) begin
        chk({tag, "_busy_phase"}, {60'd0, busy, done, WE_HI, WE_LO}, {60'd0, 4'b1000});
        if (k == inject) begin
          start = 1'b1; op = 3'b100; A = 32'hDEAD_BEEF;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      start = 1'b0;
    end
    chk({tag, "_pulse"}, {60'd0, busy, done, WE_HI, WE_LO}, {60'd0, 4'b0111});
    chk({tag, "_hilo"}, {HI_wdata, LO_wdata}, {exp_hi, exp_lo});
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {60'd0, busy, done, WE_HI, WE_LO}, 64'd0);
    chk("reset_data", {HI_wdata, LO_wdata}, 64'd0);
    @(negedge clk);
    clr = 1'b0;

    run_op("mult_neg",   3'b000, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
    run_op("multu_max",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("div_neg",    3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_negdsr", 3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("divu",       3'b011, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 0);
    run_op("div_zero",   3'b010, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 0);
    run_op("div_ovf",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);

    // MTHI issued in the DONE cycle: must be accepted; LO data holds.
    issue(3'b100, 32'h0000_1234, 32'd0);
    chk("mthi_ctrl", {60'd0, busy, done, WE_HI, WE_LO}, {60'd0, 4'b0110});
    chk("mthi_data", {HI_wdata, LO_wdata}, {32'h0000_1234, 32'h8000_0000});
    @(posedge clk);
    #1;
    chk("mthi_pulse_end", {60'd0, busy, done, WE_HI, WE_LO}, 64'd0);

    issue(3'b101, 32'h0000_ABCD, 32'd0);
    chk("mtlo_ctrl", {60'd0, busy, done, WE_HI, WE_LO}, {60'd0, 4'b0101});
    chk("mtlo_data", {HI_wdata, LO_wdata}, {32'h0000_1234, 32'h0000_ABCD});

    // Reserved op: nothing happens.
    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    chk("rsvd_ctrl", {60'd0, busy, done, WE_HI, WE_LO}, 64'd0);
    chk("rsvd_data", {HI_wdata, LO_wdata}, {32'h0000_1234, 32'h0000_ABCD});

    // MTHI request pulsed mid-divide is ignored.
    run_op("divu_inject", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    // Abort a DIVU at iteration 10.
    issue(3'b011, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_clr_busy", {63'd0, busy}, 64'd1);
    clr = 1'b1;
    #1;
    chk("clr_ctrl", {60'd0, busy, done, WE_HI, WE_LO}, 64'd0);
    chk("clr_data", {HI_wdata, LO_wdata}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      chk("post_clr_quiet", {60'd0, busy, done, WE_HI, WE_LO}, 64'd0);
    end

    run_op("multu_small", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
